// File: rtl/branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// branch_resolve_ctrl
//
// Purpose:
//   Branch resolution for the ID stage of a 5-stage MIPS pipeline. A decoded
//   branch is held in ID until its source operands are final. The branch is
//   then evaluated and a one-cycle redirect (target PC) is issued to IF. A
//   one-cycle link-register write request is issued for BGEZAL/BLTZAL.
//   Saturating statistics counters track resolved branches, taken branches
//   and cycles spent waiting for operands.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   id_valid         ID holds a valid instruction
//   id_op, id_rt     opcode [31:26] and rt field [20:16]
//   id_pc, id_imm    branch PC and 16-bit offset
//   rs_val, rt_val   forwarded operands
//   rs_ready         rs_val is final
//   rt_ready         rt_val is final
//   flush            exception/eret flush, highest priority
//   stall_id         hold IF/ID (combinational)
//   redirect_valid   one-cycle pulse: branch taken
//   redirect_pc      taken target, qualified by redirect_valid
//   link_we          one-cycle pulse: write link register
//   link_waddr       link register number, qualified by link_we
//   link_wdata       id_pc + 8, qualified by link_we
//   br_count         branches resolved (saturating)
//   taken_count      branches taken (saturating)
//   stall_count      cycles spent in WAIT (saturating)
//   dbg_state        current FSM state (0 = IDLE, 1 = WAIT)
//
// Handshake:
//   The ID stage offers a branch with id_valid. The branch is accepted
//   (resolved) in the first cycle where its needed operands are ready and no
//   flush is present. Until then stall_id is high in the same cycle, and the
//   ID inputs are expected to stay stable. Results appear one cycle after the
//   resolve cycle as single-cycle pulses; there is no back-pressure on them.
// -----------------------------------------------------------------------------
module branch_resolve_ctrl #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned LINK_REG = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [5:0]       id_op,
  input  logic [4:0]       id_rt,
  input  logic [31:0]      id_pc,
  input  logic [15:0]      id_imm,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  input  logic             rs_ready,
  input  logic             rt_ready,
  input  logic             flush,
  output logic             stall_id,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             link_we,
  output logic [4:0]       link_waddr,
  output logic [31:0]      link_wdata,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] taken_count,
  output logic [CNT_W-1:0] stall_count,
  output logic             dbg_state
);

  // ---------------------------------------------------------------------------
  // Opcode / REGIMM rt encodings
  // ---------------------------------------------------------------------------
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  localparam logic [4:0]       LINK_ADDR = 5'(LINK_REG);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + CNT_ONE);
  endfunction

  // ---------------------------------------------------------------------------
  // Decode and condition evaluation
  // ---------------------------------------------------------------------------
  logic is_branch;
  logic need_rt;
  logic is_link;
  logic cond;
  logic rs_zero;
  logic rs_neg;

  assign rs_zero = (rs_val == 32'd0);
  assign rs_neg  = rs_val[31];

  always_comb begin
    is_branch = 1'b0;
    need_rt   = 1'b0;
    is_link   = 1'b0;
    cond      = 1'b0;
    case (id_op)
      OP_BEQ: begin
        is_branch = 1'b1;
        need_rt   = 1'b1;
        cond      = (rs_val == rt_val);
      end
      OP_BNE: begin
        is_branch = 1'b1;
        need_rt   = 1'b1;
        cond      = (rs_val != rt_val);
      end
      OP_BLEZ: begin
        is_branch = 1'b1;
        cond      = rs_neg | rs_zero;
      end
      OP_BGTZ: begin
        is_branch = 1'b1;
        cond      = ~rs_neg & ~rs_zero;
      end
      OP_REGIMM: begin
        case (id_rt)
          RT_BLTZ: begin
            is_branch = 1'b1;
            cond      = rs_neg;
          end
          RT_BGEZ: begin
            is_branch = 1'b1;
            cond      = ~rs_neg;
          end
          RT_BLTZAL: begin
            is_branch = 1'b1;
            is_link   = 1'b1;
            cond      = rs_neg;
          end
          RT_BGEZAL: begin
            is_branch = 1'b1;
            is_link   = 1'b1;
            cond      = ~rs_neg;
          end
          default: begin
            is_branch = 1'b0;
          end
        endcase
      end
      default: begin
        is_branch = 1'b0;
      end
    endcase
  end

  // rt only matters for the two-operand compares.
  logic ops_ready;
  logic br_present;
  logic resolve;

  assign ops_ready  = rs_ready & (rt_ready | ~need_rt);
  assign br_present = id_valid & is_branch;
  assign resolve    = br_present & ops_ready & ~flush;

  // Held low during reset so that every output is quiet while rst is high.
  assign stall_id = br_present & ~ops_ready & ~flush & ~rst;

  // Target arithmetic wraps modulo 2^32 by construction.
  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] link_addr;

  assign br_offset = {{14{id_imm[15]}}, id_imm, 2'b00};
  assign br_target = id_pc + 32'd4 + br_offset;
  assign link_addr = id_pc + 32'd8;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  state_e           state_q,       state_d;
  logic             redir_valid_q, redir_valid_d;
  logic [31:0]      redir_pc_q,    redir_pc_d;
  logic             link_we_q,     link_we_d;
  logic [4:0]       link_waddr_q,  link_waddr_d;
  logic [31:0]      link_wdata_q,  link_wdata_d;
  logic [CNT_W-1:0] br_cnt_q,      br_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q,   taken_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q,   stall_cnt_d;

  always_comb begin
    state_d       = IDLE;
    redir_valid_d = 1'b0;
    redir_pc_d    = 32'd0;
    link_we_d     = 1'b0;
    link_waddr_d  = 5'd0;
    link_wdata_d  = 32'd0;
    br_cnt_d      = br_cnt_q;
    taken_cnt_d   = taken_cnt_q;
    stall_cnt_d   = stall_cnt_q;

    // A branch that cannot resolve parks in WAIT; flush always lands in IDLE.
    if (!flush && br_present && !ops_ready) begin
      state_d = WAIT;
    end

    // Every WAIT cycle counts, including the one in which the branch
    // finally resolves; a flushed cycle does not.
    if (state_q == WAIT && !flush) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end

    if (resolve) begin
      br_cnt_d = sat_inc(br_cnt_q);
      if (cond) begin
        redir_valid_d = 1'b1;
        redir_pc_d    = br_target;
        taken_cnt_d   = sat_inc(taken_cnt_q);
      end
      // Link write happens whether or not the branch is taken.
      if (is_link) begin
        link_we_d    = 1'b1;
        link_waddr_d = LINK_ADDR;
        link_wdata_d = link_addr;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= 32'd0;
      link_we_q     <= 1'b0;
      link_waddr_q  <= 5'd0;
      link_wdata_q  <= 32'd0;
      br_cnt_q      <= '0;
      taken_cnt_q   <= '0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      link_we_q     <= link_we_d;
      link_waddr_q  <= link_waddr_d;
      link_wdata_q  <= link_wdata_d;
      br_cnt_q      <= br_cnt_d;
      taken_cnt_q   <= taken_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign redirect_valid = redir_valid_q;
  assign redirect_pc    = redir_pc_q;
  assign link_we        = link_we_q;
  assign link_waddr     = link_waddr_q;
  assign link_wdata     = link_wdata_q;
  assign br_count       = br_cnt_q;
  assign taken_count    = taken_cnt_q;
  assign stall_count    = stall_cnt_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_ctrl
//
// Directed vectors with hand-computed expected results. The driver pushes the
// expected redirect/link pulse into exp_q when it issues a branch; a monitor
// pops and compares whenever the DUT presents a pulse. A second instance with
// CNT_W=2 shares the same stimulus to exercise counter saturation.
// -----------------------------------------------------------------------------
module tb_branch_resolve_ctrl;

  localparam int CNT_W = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        id_valid = 1'b0;
  logic [5:0]  id_op    = 6'd0;
  logic [4:0]  id_rt    = 5'd0;
  logic [31:0] id_pc    = 32'd0;
  logic [15:0] id_imm   = 16'd0;
  logic [31:0] rs_val   = 32'd0;
  logic [31:0] rt_val   = 32'd0;
  logic        rs_ready = 1'b0;
  logic        rt_ready = 1'b0;
  logic        flush    = 1'b0;

  logic             stall_id, redirect_valid, link_we, dbg_state;
  logic [31:0]      redirect_pc, link_wdata;
  logic [4:0]       link_waddr;
  logic [CNT_W-1:0] br_count, taken_count, stall_count;

  logic        s_stall_id, s_redirect_valid, s_link_we, s_dbg_state;
  logic [31:0] s_redirect_pc, s_link_wdata;
  logic [4:0]  s_link_waddr;
  logic [1:0]  s_br_count, s_taken_count, s_stall_count;

  branch_resolve_ctrl #(.CNT_W(CNT_W), .LINK_REG(31)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_rt(id_rt),
    .id_pc(id_pc), .id_imm(id_imm), .rs_val(rs_val), .rt_val(rt_val),
    .rs_ready(rs_ready), .rt_ready(rt_ready), .flush(flush),
    .stall_id(stall_id), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .link_we(link_we), .link_waddr(link_waddr),
    .link_wdata(link_wdata), .br_count(br_count), .taken_count(taken_count),
    .stall_count(stall_count), .dbg_state(dbg_state)
  );

  branch_resolve_ctrl #(.CNT_W(2), .LINK_REG(31)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_rt(id_rt),
    .id_pc(id_pc), .id_imm(id_imm), .rs_val(rs_val), .rt_val(rt_val),
    .rs_ready(rs_ready), .rt_ready(rt_ready), .flush(flush),
    .stall_id(s_stall_id), .redirect_valid(s_redirect_valid),
    .redirect_pc(s_redirect_pc), .link_we(s_link_we), .link_waddr(s_link_waddr),
    .link_wdata(s_link_wdata), .br_count(s_br_count),
    .taken_count(s_taken_count), .stall_count(s_stall_count),
    .dbg_state(s_dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [65:0] exp_q[$];   // {redirect_valid, redirect_pc, link_we, link_wdata}
  int m_br = 0, m_taken = 0, m_stall = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic chk_counters(input string tag);
    chk({tag, ".br_count"},    32'(br_count),    32'(m_br));
    chk({tag, ".taken_count"}, 32'(taken_count), 32'(m_taken));
    chk({tag, ".stall_count"}, 32'(stall_count), 32'(m_stall));
    chk({tag, ".sat_br"},      32'(s_br_count),    32'(sat3(m_br)));
    chk({tag, ".sat_taken"},   32'(s_taken_count), 32'(sat3(m_taken)));
    chk({tag, ".sat_stall"},   32'(s_stall_count), 32'(sat3(m_stall)));
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops on every observed pulse
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst && (redirect_valid || link_we)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, redirect_valid, link_we}, 32'd0);
      end else begin
        logic [65:0] e;
        e = exp_q.pop_front();
        chk("redirect_valid", 32'(redirect_valid), 32'(e[65]));
        if (e[65]) chk("redirect_pc", redirect_pc, e[64:33]);
        chk("link_we", 32'(link_we), 32'(e[32]));
        if (e[32]) begin
          chk("link_wdata", link_wdata, e[31:0]);
          chk("link_waddr", 32'(link_waddr), 32'd31);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Vectors and driver tasks
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [31:0] pc;
    logic [15:0] imm;
    logic [31:0] rsv;
    logic [31:0] rtv;
    int          rs_dly;
    int          rt_dly;
    int          exp_stall;
    bit          is_br;
    bit          exp_rv;
    logic [31:0] exp_pc;
    bit          exp_lw;
    logic [31:0] exp_wd;
  } vec_t;

  function automatic vec_t mk(input logic [5:0] op, input logic [4:0] rt,
                              input logic [31:0] pc, input logic [15:0] imm,
                              input logic [31:0] rsv, input logic [31:0] rtv,
                              input int rs_dly, input int rt_dly, input int exp_stall,
                              input bit is_br, input bit exp_rv, input logic [31:0] exp_pc,
                              input bit exp_lw, input logic [31:0] exp_wd);
    vec_t v;
    v.op = op; v.rt = rt; v.pc = pc; v.imm = imm; v.rsv = rsv; v.rtv = rtv;
    v.rs_dly = rs_dly; v.rt_dly = rt_dly; v.exp_stall = exp_stall;
    v.is_br = is_br; v.exp_rv = exp_rv; v.exp_pc = exp_pc;
    v.exp_lw = exp_lw; v.exp_wd = exp_wd;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    id_valid = 1'b1;
    id_op    = v.op;
    id_rt    = v.rt;
    id_pc    = v.pc;
    id_imm   = v.imm;
    rs_val   = v.rsv;
    rt_val   = v.rtv;
  endtask

  task automatic expect_vec(input vec_t v);
    if (v.exp_rv || v.exp_lw) exp_q.push_back({v.exp_rv, v.exp_pc, v.exp_lw, v.exp_wd});
    if (v.is_br) begin
      m_br++;
      if (v.exp_rv) m_taken++;
    end
    m_stall += v.exp_stall;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(posedge clk); #1;
    drive(v);
    expect_vec(v);
    for (int c = 0; c <= v.exp_stall; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      rs_ready = (c >= v.rs_dly);
      rt_ready = (c >= v.rt_dly);
      @(negedge clk);
      chk({tag, ".stall_id"}, 32'(stall_id), (c < v.exp_stall) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    id_valid = 1'b0; rs_ready = 1'b0; rt_ready = 1'b0;
    @(negedge clk);
    chk_counters(tag);
  endtask

  vec_t vecs[$];

  initial begin
    // op        rt        pc            imm       rs            rt        rsd rtd stl br rv exp_pc        lw exp_wd
    vecs.push_back(mk(6'b000100, 5'd0,     32'h00400000, 16'h0004, 32'd5,        32'd5, 0, 0, 0, 1, 1, 32'h00400014, 0, 32'h0));
    vecs.push_back(mk(6'b000101, 5'd0,     32'h00400020, 16'h0008, 32'd7,        32'd7, 0, 0, 0, 1, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(6'b000111, 5'd0,     32'h00400040, 16'h0010, 32'd1,        32'd0, 3, 0, 3, 1, 1, 32'h00400084, 0, 32'h0));
    vecs.push_back(mk(6'b000111, 5'd0,     32'h00400090, 16'h0010, 32'd0,        32'd0, 0, 5, 0, 1, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(6'b000001, 5'b10000, 32'h00400100, 16'hFFFF, 32'h80000000, 32'd0, 0, 0, 0, 1, 1, 32'h00400100, 1, 32'h00400108));
    vecs.push_back(mk(6'b000001, 5'b10000, 32'h00400100, 16'hFFFF, 32'h00000000, 32'd0, 0, 0, 0, 1, 0, 32'h0,        1, 32'h00400108));
    vecs.push_back(mk(6'b000100, 5'd0,     32'hFFFFFFF8, 16'h0002, 32'd0,        32'd0, 0, 0, 0, 1, 1, 32'h00000004, 0, 32'h0));
    vecs.push_back(mk(6'b000101, 5'd0,     32'h00400200, 16'hFFFC, 32'd3,        32'd4, 0, 2, 2, 1, 1, 32'h004001F4, 0, 32'h0));
    vecs.push_back(mk(6'b000110, 5'd0,     32'h00400300, 16'h0001, 32'hFFFFFFFF, 32'd0, 0, 0, 0, 1, 1, 32'h00400308, 0, 32'h0));
    vecs.push_back(mk(6'b000001, 5'b00001, 32'h00400400, 16'h0000, 32'd0,        32'd0, 0, 0, 0, 1, 1, 32'h00400404, 0, 32'h0));
    vecs.push_back(mk(6'b000001, 5'b10001, 32'h00400500, 16'h0003, 32'h80000001, 32'd0, 0, 0, 0, 1, 0, 32'h0,        1, 32'h00400508));
    vecs.push_back(mk(6'b001000, 5'd0,     32'h00400520, 16'h0004, 32'd0,        32'd0, 4, 4, 0, 0, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(6'b000001, 5'b00010, 32'h00400540, 16'h0004, 32'h80000000, 32'd0, 4, 0, 0, 0, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(6'b000110, 5'd0,     32'h00400600, 16'h0002, 32'd5,        32'd0, 1, 0, 1, 1, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(6'b000001, 5'b00000, 32'h00400700, 16'h0002, 32'd0,        32'd0, 0, 0, 0, 1, 0, 32'h0,        0, 32'h0));
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    vec_t va, vb, vf;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst.link_we",        32'(link_we),        32'd0);
    chk("rst.stall_id",       32'(stall_id),       32'd0);
    chk("rst.dbg_state",      32'(dbg_state),      32'd0);
    chk_counters("rst");
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back resolves in consecutive cycles
    va = mk(6'b000100, 5'd0,     32'h00400800, 16'h0001, 32'd1, 32'd1, 0, 0, 0, 1, 1, 32'h00400808, 0, 32'h0);
    vb = mk(6'b000001, 5'b10001, 32'h00400804, 16'h0002, 32'd0, 32'd0, 0, 0, 0, 1, 1, 32'h00400810, 1, 32'h0040080C);
    @(posedge clk); #1;
    drive(va); rs_ready = 1'b1; rt_ready = 1'b1; expect_vec(va);
    @(posedge clk); #1;
    drive(vb); expect_vec(vb);
    @(posedge clk); #1;
    id_valid = 1'b0; rs_ready = 1'b0; rt_ready = 1'b0;
    @(negedge clk);
    chk_counters("b2b");

    // Flush on the ready cycle of a waiting BEQ: no resolve, back to IDLE
    vf = mk(6'b000100, 5'd0, 32'h00400900, 16'h0004, 32'd2, 32'd2, 0, 0, 0, 1, 1, 32'h00400914, 0, 32'h0);
    @(posedge clk); #1;
    drive(vf); rs_ready = 1'b0; rt_ready = 1'b1;
    @(negedge clk);
    chk("flush.stall_pre", 32'(stall_id), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush.in_wait", 32'(dbg_state), 32'd1);
    @(posedge clk); #1;
    rs_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush.stall_lo", 32'(stall_id), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; id_valid = 1'b0; rs_ready = 1'b0; rt_ready = 1'b0;
    m_stall += 1;  // one unflushed WAIT cycle
    @(negedge clk);
    chk("flush.state", 32'(dbg_state), 32'd0);
    chk_counters("flush");

    // Flush with a ready branch in IDLE suppresses the resolve entirely
    @(posedge clk); #1;
    drive(vf); rs_ready = 1'b1; rt_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; id_valid = 1'b0;
    @(negedge clk);
    chk_counters("flush_idle");

    // Flush right after a resolve does not retract the registered pulse
    @(posedge clk); #1;
    drive(vf); expect_vec(vf);
    @(posedge clk); #1;
    flush = 1'b1; id_valid = 1'b0;
    @(negedge clk);
    chk_counters("flush_late");
    @(posedge clk); #1;
    flush = 1'b0; rs_ready = 1'b0; rt_ready = 1'b0;

    // Reset in the middle of WAIT
    @(posedge clk); #1;
    drive(vf); rs_ready = 1'b0; rt_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstw.in_wait", 32'(dbg_state), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstw.dbg_state",      32'(dbg_state),      32'd0);
    chk("rstw.stall_id",       32'(stall_id),       32'd0);
    chk("rstw.redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rstw.link_we",        32'(link_we),        32'd0);
    m_br = 0; m_taken = 0; m_stall = 0;
    chk_counters("rstw");
    id_valid = 1'b0; rt_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Normal operation after reset
    run_vec(vecs[0], "post_rst");

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
